writeback_block: RTL and testbench

WRITEBACK_BLOCK -- requirements
Module: writeback_block

---
 rtl/writeback_block.sv | 145 ++++++++++++++
 tb/tb_writeback_block.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_block.sv
// rtl/writeback_block.sv - writeback stage: source select, load alignment, memory-response wait.
// Optional WB_FORWARD_EN adds pending-load outputs for load-use hazard detection.
module writeback_block #(
  parameter int WORD       = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  flush_i,
  input  logic                  reg_file_write_en_i,
  input  logic [1:0]            reg_file_input_ctrl_sig_i,
  input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
  input  logic [WORD-1:0]       alu_result_i,
  input  logic [WORD-1:0]       program_counter_i,
  input  logic [1:0]            load_size_i,
  input  logic                  load_signed_i,
  input  logic [1:0]            mem_addr_lsb_i,
  input  logic                  mem_data_valid_i,
  input  logic [WORD-1:0]       mem_data_i,
  output logic                  reg_file_write_en_o,
  output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
  output logic [WORD-1:0]       reg_data_o
`ifdef WB_FORWARD_EN
  ,
  output logic                  fwd_pending_o,
  output logic [ADDR_WIDTH-1:0] fwd_pending_addr_o
`endif
);

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_MEM  = 2'd1;
  localparam logic [1:0] SRC_LINK = 2'd2;
  localparam logic [1:0] SRC_RSV  = 2'd3;

  state_t                  state_q, state_d;
  logic                    accept;
  logic                    wait_commit;
  logic [WORD-1:0]         accept_data;
  logic                    pend_en_q;
  logic [ADDR_WIDTH-1:0]   pend_addr_q;
  logic [1:0]              pend_size_q;
  logic                    pend_sgn_q;
  logic [1:0]              pend_lsb_q;

  // Little-endian lane select followed by zero/sign extension.
  function automatic logic [WORD-1:0] align_load(input logic [WORD-1:0] d, input logic [1:0] size,
                                                 input logic sgn, input logic [1:0] lsb);
    logic [15:0] half;
    logic [7:0]  lane;
    half = lsb[1] ? d[31:16] : d[15:0];
    case (lsb)
      2'd0:    lane = d[7:0];
      2'd1:    lane = d[15:8];
      2'd2:    lane = d[23:16];
      default: lane = d[31:24];
    endcase
    case (size)
      2'd0:    align_load = d;
      2'd1:    align_load = {{(WORD-16){sgn & half[15]}}, half};
      2'd2:    align_load = {{(WORD-8){sgn & lane[7]}}, lane};
      default: align_load = '0;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ready_o     = 1'b0;
    wait_commit = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = !flush_i;
        if (valid_i && !flush_i && reg_file_input_ctrl_sig_i == SRC_MEM && !mem_data_valid_i)
          state_d = WAIT_MEM;
      end
      WAIT_MEM: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (mem_data_valid_i) begin
          state_d     = IDLE;
          wait_commit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = valid_i && ready_o;

  always_comb begin
    accept_data = alu_result_i;
    case (reg_file_input_ctrl_sig_i)
      SRC_LINK: accept_data = program_counter_i + WORD'(2);
      SRC_MEM:  accept_data = align_load(mem_data_i, load_size_i, load_signed_i, mem_addr_lsb_i);
      default:  accept_data = alu_result_i;
    endcase
  end

  // Address/data only move on a real write so they hold the last committed value.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      reg_file_write_en_o <= 1'b0;
      reg_dest_addr_o     <= '0;
      reg_data_o          <= '0;
      pend_en_q           <= 1'b0;
      pend_addr_q         <= '0;
      pend_size_q         <= '0;
      pend_sgn_q          <= 1'b0;
      pend_lsb_q          <= '0;
    end else begin
      reg_file_write_en_o <= 1'b0;
      if (accept) begin
        if (reg_file_input_ctrl_sig_i == SRC_MEM && !mem_data_valid_i) begin
          pend_en_q   <= reg_file_write_en_i;
          pend_addr_q <= reg_dest_addr_i;
          pend_size_q <= load_size_i;
          pend_sgn_q  <= load_signed_i;
          pend_lsb_q  <= mem_addr_lsb_i;
        end else if (reg_file_write_en_i && reg_file_input_ctrl_sig_i != SRC_RSV) begin
          reg_file_write_en_o <= 1'b1;
          reg_dest_addr_o     <= reg_dest_addr_i;
          reg_data_o          <= accept_data;
        end
      end else if (wait_commit && pend_en_q) begin
        reg_file_write_en_o <= 1'b1;
        reg_dest_addr_o     <= pend_addr_q;
        reg_data_o          <= align_load(mem_data_i, pend_size_q, pend_sgn_q, pend_lsb_q);
      end
    end
  end

`ifdef WB_FORWARD_EN
  assign fwd_pending_o      = (state_q == WAIT_MEM);
  assign fwd_pending_addr_o = (state_q == WAIT_MEM) ? pend_addr_q : '0;
`endif

endmodule

// File: tb/tb_writeback_block.sv
// tb/tb_writeback_block.sv - self-checking bench for writeback_block with a behavioural model.
module tb_writeback_block;
  logic        clk_i = 1'b0;
  logic        reset_i, valid_i, ready_o, flush_i, reg_file_write_en_i, load_signed_i, mem_data_valid_i;
  logic [1:0]  reg_file_input_ctrl_sig_i, load_size_i, mem_addr_lsb_i;
  logic [3:0]  reg_dest_addr_i, reg_dest_addr_o;
  logic [31:0] alu_result_i, program_counter_i, mem_data_i, reg_data_o;
  logic        reg_file_write_en_o;
`ifdef WB_FORWARD_EN
  logic        fwd_pending_o;
  logic [3:0]  fwd_pending_addr_o;
`endif

  int checks = 0;
  int errors = 0;

  // Model: pending load (if any) and the expected register-file port.
  bit          m_wait, p_en, p_sgn;
  logic [3:0]  p_addr;
  logic [1:0]  p_size, p_lsb;
  logic        exp_en;
  logic [3:0]  exp_addr;
  logic [31:0] exp_data;

  always #5 clk_i = ~clk_i;

  writeback_block #(.WORD(32), .ADDR_WIDTH(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .ready_o(ready_o), .flush_i(flush_i),
    .reg_file_write_en_i(reg_file_write_en_i), .reg_file_input_ctrl_sig_i(reg_file_input_ctrl_sig_i),
    .reg_dest_addr_i(reg_dest_addr_i), .alu_result_i(alu_result_i), .program_counter_i(program_counter_i),
    .load_size_i(load_size_i), .load_signed_i(load_signed_i), .mem_addr_lsb_i(mem_addr_lsb_i),
    .mem_data_valid_i(mem_data_valid_i), .mem_data_i(mem_data_i),
    .reg_file_write_en_o(reg_file_write_en_o), .reg_dest_addr_o(reg_dest_addr_o), .reg_data_o(reg_data_o)
`ifdef WB_FORWARD_EN
    , .fwd_pending_o(fwd_pending_o), .fwd_pending_addr_o(fwd_pending_addr_o)
`endif
  );

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] size,
                                           input logic sgn, input logic [1:0] lsb);
    logic [31:0] v;
    int sh;
    case (size)
      2'd0: v = d;
      2'd1: begin
        sh = lsb[1] ? 16 : 0;
        v = (d >> sh) & 32'hFFFF;
        if (sgn && v >= 32'h8000) v = v - 32'h10000;
      end
      2'd2: begin
        sh = 8 * int'(lsb);
        v = (d >> sh) & 32'hFF;
        if (sgn && v >= 32'h80) v = v - 32'h100;
      end
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic clear_inputs;
    reset_i = 0; valid_i = 0; flush_i = 0; reg_file_write_en_i = 0; reg_file_input_ctrl_sig_i = 0;
    reg_dest_addr_i = 0; alu_result_i = 0; program_counter_i = 0; load_size_i = 0; load_signed_i = 0;
    mem_addr_lsb_i = 0; mem_data_valid_i = 0; mem_data_i = 0;
  endtask

  task automatic drive_instr(input logic [1:0] ctrl, input logic [3:0] dest, input logic we);
    valid_i = 1; reg_file_input_ctrl_sig_i = ctrl; reg_dest_addr_i = dest; reg_file_write_en_i = we;
  endtask

  // Advance the model by the current inputs, then clock the DUT and settle.
  task automatic clk_step;
    if (reset_i) begin
      m_wait = 0; exp_en = 0; exp_addr = 0; exp_data = 0;
    end else begin
      exp_en = 0;
      if (!m_wait) begin
        if (valid_i && !flush_i) begin
          if (reg_file_input_ctrl_sig_i == 2'd1 && !mem_data_valid_i) begin
            m_wait = 1; p_en = reg_file_write_en_i; p_addr = reg_dest_addr_i;
            p_size = load_size_i; p_sgn = load_signed_i; p_lsb = mem_addr_lsb_i;
          end else if (reg_file_write_en_i && reg_file_input_ctrl_sig_i != 2'd3) begin
            exp_en = 1; exp_addr = reg_dest_addr_i;
            case (reg_file_input_ctrl_sig_i)
              2'd0: exp_data = alu_result_i;
              2'd2: exp_data = program_counter_i + 32'd2;
              default: exp_data = ref_load(mem_data_i, load_size_i, load_signed_i, mem_addr_lsb_i);
            endcase
          end
        end
      end else if (flush_i) begin
        m_wait = 0;
      end else if (mem_data_valid_i) begin
        m_wait = 0;
        if (p_en) begin
          exp_en = 1; exp_addr = p_addr; exp_data = ref_load(mem_data_i, p_size, p_sgn, p_lsb);
        end
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    clear_inputs();
    reset_i = 1; mem_data_valid_i = 1; drive_instr(2'd0, 4'd5, 1'b1); alu_result_i = $urandom;
    clk_step(); clk_step();
    clear_inputs(); #1;
    checks++;
    if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {1'b0, 4'd0, 32'd0}) begin
      errors++; $display("FAIL reset_outputs got %b/%0d/%h want 0/0/0", reg_file_write_en_o, reg_dest_addr_o, reg_data_o);
    end
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
  endtask

  task automatic test_alu_link_reserved;
    drive_instr(2'd0, 4'd3, 1'b1); alu_result_i = 32'h0000_1234; #1;
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("FAIL alu_ready got %b want 1", ready_o); end
    clk_step();
    checks++;
    if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {1'b1, 4'd3, 32'h0000_1234}) begin
      errors++; $display("FAIL alu_commit got %b/%0d/%h want 1/3/00001234", reg_file_write_en_o, reg_dest_addr_o, reg_data_o);
    end
    valid_i = 0; clk_step();
    checks++;
    if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {1'b0, 4'd3, 32'h0000_1234}) begin
      errors++; $display("FAIL alu_pulse_hold got %b/%0d/%h want 0/3/00001234", reg_file_write_en_o, reg_dest_addr_o, reg_data_o);
    end
    drive_instr(2'd2, 4'd14, 1'b1); program_counter_i = 32'hFFFF_FFFE; clk_step();
    checks++;
    if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {1'b1, 4'd14, 32'h0}) begin
      errors++; $display("FAIL link_wrap got %b/%0d/%h want 1/14/00000000", reg_file_write_en_o, reg_dest_addr_o, reg_data_o);
    end
    drive_instr(2'd3, 4'd7, 1'b1); alu_result_i = 32'hDEAD_BEEF; clk_step();
    checks++;
    if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {1'b0, 4'd14, 32'h0}) begin
      errors++; $display("FAIL reserved_src got %b/%0d/%h want 0/14/00000000", reg_file_write_en_o, reg_dest_addr_o, reg_data_o);
    end
    clear_inputs();
  endtask

  task automatic test_load_same_cycle;
    drive_instr(2'd1, 4'd9, 1'b1); load_size_i = 2'd2; load_signed_i = 1; mem_addr_lsb_i = 2'd2;
    mem_data_valid_i = 1; mem_data_i = 32'h0080_0000; clk_step();
    checks++;
    if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {1'b1, 4'd9, 32'hFFFF_FF80}) begin
      errors++; $display("FAIL load_byte_signed got %b/%0d/%h want 1/9/ffffff80", reg_file_write_en_o, reg_dest_addr_o, reg_data_o);
    end
    drive_instr(2'd1, 4'd10, 1'b1); load_size_i = 2'd1; load_signed_i = 0; mem_data_i = 32'h8001_0000; clk_step();
    checks++;
    if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {1'b1, 4'd10, 32'h0000_8001}) begin
      errors++; $display("FAIL load_half_unsigned got %b/%0d/%h want 1/10/00008001", reg_file_write_en_o, reg_dest_addr_o, reg_data_o);
    end
    clear_inputs();
  endtask

  task automatic test_wait_mem;
    drive_instr(2'd1, 4'd6, 1'b1); load_size_i = 2'd0; mem_addr_lsb_i = 2'd3; clk_step();
    drive_instr(2'd0, 4'd2, 1'b1); alu_result_i = 32'h0000_A5A5;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ready_o, reg_file_write_en_o} !== 2'b00) begin
        errors++; $display("FAIL wait_stall cycle %0d got ready %b en %b want 0 0", i, ready_o, reg_file_write_en_o);
      end
`ifdef WB_FORWARD_EN
      checks++;
      if ({fwd_pending_o, fwd_pending_addr_o} !== {1'b1, 4'd6}) begin
        errors++; $display("FAIL wait_fwd got %b/%0d want 1/6", fwd_pending_o, fwd_pending_addr_o);
      end
`endif
      if (i == 2) begin mem_data_valid_i = 1; mem_data_i = 32'hCAFE_F00D; end
      clk_step();
    end
    mem_data_valid_i = 0; #1;
    checks++;
    if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o, ready_o} !== {1'b1, 4'd6, 32'hCAFE_F00D, 1'b1}) begin
      errors++; $display("FAIL wait_commit got %b/%0d/%h ready %b want 1/6/cafef00d ready 1", reg_file_write_en_o, reg_dest_addr_o, reg_data_o, ready_o);
    end
    clk_step();
    checks++;
    if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {1'b1, 4'd2, 32'h0000_A5A5}) begin
      errors++; $display("FAIL held_valid_after_wait got %b/%0d/%h want 1/2/0000a5a5", reg_file_write_en_o, reg_dest_addr_o, reg_data_o);
    end
    clear_inputs(); clk_step();
  endtask

  task automatic test_flush;
    drive_instr(2'd1, 4'd11, 1'b1); clk_step();
    valid_i = 0; clk_step();
    flush_i = 1; mem_data_valid_i = 1; mem_data_i = 32'h1357_9BDF; #1;
    checks++;
    if (ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", ready_o); end
    clk_step();
    flush_i = 0; mem_data_valid_i = 0; #1;
    checks++;
    if ({reg_file_write_en_o, ready_o} !== 2'b01) begin
      errors++; $display("FAIL flush_drop got en %b ready %b want en 0 ready 1", reg_file_write_en_o, ready_o);
    end
    flush_i = 1; drive_instr(2'd0, 4'd12, 1'b1); alu_result_i = 32'h0BAD_0BAD; clk_step();
    checks++;
    if (reg_file_write_en_o !== 1'b0) begin errors++; $display("FAIL flush_beats_valid got en %b want 0", reg_file_write_en_o); end
    clear_inputs();
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    drive_instr(2'd1, 4'd8, 1'b1); clk_step();
    valid_i = 0; clk_step();
    reset_i = 1; mem_data_valid_i = 1; mem_data_i = 32'hFFFF_FFFF; clk_step();
    clear_inputs(); #1;
    checks++;
    if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o, ready_o} !== {1'b0, 4'd0, 32'd0, 1'b1}) begin
      errors++; $display("FAIL reset_mid_wait got %b/%0d/%h ready %b want 0/0/0 ready 1", reg_file_write_en_o, reg_dest_addr_o, reg_data_o, ready_o);
    end
    for (int i = 1; i <= 4; i++) begin
      v = $urandom; drive_instr(2'd0, 4'(i), 1'b1); alu_result_i = v; clk_step();
      checks++;
      if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {1'b1, 4'(i), v}) begin
        errors++; $display("FAIL back_to_back %0d got %b/%0d/%h want 1/%0d/%h", i, reg_file_write_en_o, reg_dest_addr_o, reg_data_o, i, v);
      end
    end
    clear_inputs(); clk_step();
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      reset_i = ($urandom_range(0, 49) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      valid_i = $urandom_range(0, 1);
      mem_data_valid_i = ($urandom_range(0, 2) == 0);
      reg_file_write_en_i = ($urandom_range(0, 4) != 0);
      reg_file_input_ctrl_sig_i = 2'($urandom); reg_dest_addr_i = 4'($urandom);
      alu_result_i = $urandom; program_counter_i = $urandom; mem_data_i = $urandom;
      load_size_i = 2'($urandom); load_signed_i = 1'($urandom); mem_addr_lsb_i = 2'($urandom);
      #1;
      checks++;
      if (ready_o !== (!m_wait && !flush_i)) begin
        errors++; $display("FAIL rand_ready cycle %0d got %b want %b", n, ready_o, !m_wait && !flush_i);
      end
      clk_step();
      checks++;
      if ({reg_file_write_en_o, reg_dest_addr_o, reg_data_o} !== {exp_en, exp_addr, exp_data}) begin
        errors++; $display("FAIL rand_port cycle %0d got %b/%0d/%h want %b/%0d/%h", n, reg_file_write_en_o, reg_dest_addr_o, reg_data_o, exp_en, exp_addr, exp_data);
      end
`ifdef WB_FORWARD_EN
      checks++;
      if ({fwd_pending_o, fwd_pending_addr_o} !== {m_wait, m_wait ? p_addr : 4'd0}) begin
        errors++; $display("FAIL rand_fwd cycle %0d got %b/%0d want %b/%0d", n, fwd_pending_o, fwd_pending_addr_o, m_wait, m_wait ? p_addr : 4'd0);
      end
`endif
    end
    clear_inputs();
  endtask

  initial begin
    m_wait = 0; p_en = 0; p_sgn = 0; p_addr = 0; p_size = 0; p_lsb = 0;
    exp_en = 0; exp_addr = 0; exp_data = 0;
    clear_inputs();
    @(posedge clk_i); #1;
    test_reset();
    test_alu_link_reserved();
    test_load_same_cycle();
    test_wait_mem();
    test_flush();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
